sccb_cfg_seq: RTL and testbench

- Upstream feeder for the `sccb` master.
- Walks an OV7670 register table and turns each entry into a 3-byte SCCB write: device ID 0x42, register address, value.
- Each byte is presented on `sccb_data` and launched with a one-cycle `sccb_start`; the sequencer then waits for the master's `byte_done` before sending the next byte.
- Sits between the top-level init trigger and `sccb`; reports completion or a timeout error to the top level.

---
 rtl/ov7670_pkg.sv | 23 ++
 rtl/ov7670_reg_rom.sv | 22 ++
 rtl/sccb_cfg_seq.sv | 165 ++++++++++++++++
 tb/tb_sccb_cfg_seq.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ov7670_pkg.sv
// rtl/ov7670_pkg.sv - shared types and constants for the OV7670 SCCB configuration sequencer
package ov7670_pkg;

   localparam logic [7:0] OV7670_WR_ID   = 8'h42;
   localparam logic [7:0] CFG_DELAY_MARK = 8'hFF;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_SEND,
      ST_WAIT,
      ST_GAP,
      ST_DELAY,
      ST_DONE,
      ST_ERR
   } cfg_state_t;

   typedef struct packed {
      logic [7:0] addr;
      logic [7:0] val;
   } cfg_entry_t;

endpackage

// File: rtl/ov7670_reg_rom.sv
// rtl/ov7670_reg_rom.sv - OV7670 register table as a combinational case ROM
module ov7670_reg_rom
   import ov7670_pkg::*;
(
   input  logic [7:0] idx,
   output cfg_entry_t entry
);

   // Table lookup; anything past the table reads as a delay marker so a
   // misconfigured entry count stalls harmlessly instead of writing junk.
   always_comb begin
      entry = '{addr: CFG_DELAY_MARK, val: 8'h00};
      case (idx)
         8'd0:    entry = '{addr: 8'h12, val: 8'h80};        // COM7 soft reset
         8'd1:    entry = '{addr: CFG_DELAY_MARK, val: 8'h00}; // settle after reset
         8'd2:    entry = '{addr: 8'h12, val: 8'h04};        // COM7 RGB output
         8'd3:    entry = '{addr: 8'h40, val: 8'hD0};        // COM15 RGB565 full range
         default: ;
      endcase
   end

endmodule

// File: rtl/sccb_cfg_seq.sv
// rtl/sccb_cfg_seq.sv - walks the OV7670 register table and feeds 3-byte writes to the sccb master
module sccb_cfg_seq
   import ov7670_pkg::*;
#(
   parameter int NUM_ENTRIES    = 4,
   parameter int GAP_CYCLES     = 100,
   parameter int DELAY_CYCLES   = 100000,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       init_go,
   input  logic       byte_done,
   output logic       sccb_start,
   output logic [7:0] sccb_data,
   output logic       sccb_last,
   output logic       busy,
   output logic       cfg_done,
   output logic       cfg_err,
   output logic [7:0] entry_idx
);

   localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
   localparam logic [TW-1:0] TO_LAST    = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [TW-1:0] TO_MAX     = '1;
   localparam logic [19:0]   GAP_LOAD   = 20'(GAP_CYCLES - 1);
   localparam logic [19:0]   DELAY_LOAD = 20'(DELAY_CYCLES - 1);
   localparam logic [7:0]    IDX_LAST   = 8'(NUM_ENTRIES - 1);

   cfg_state_t    state, state_d;
   logic [7:0]    idx, idx_d;
   logic [1:0]    ph, ph_d;
   logic [19:0]   cnt, cnt_d;
   logic [TW-1:0] tcnt, tcnt_d;
   cfg_entry_t    entry_q, entry_d;
   cfg_entry_t    rom_entry;
   logic [7:0]    data_q, data_d;
   logic          last_q, last_d;

   ov7670_reg_rom u_rom (
      .idx   (idx),
      .entry (rom_entry)
   );

   // State register.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state <= ST_IDLE;
      else        state <= state_d;
   end

   // Index, phase, counters, latched entry and the byte presented to sccb.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         idx     <= '0;
         ph      <= '0;
         cnt     <= '0;
         tcnt    <= '0;
         entry_q <= '0;
         data_q  <= '0;
         last_q  <= 1'b0;
      end else begin
         idx     <= idx_d;
         ph      <= ph_d;
         cnt     <= cnt_d;
         tcnt    <= tcnt_d;
         entry_q <= entry_d;
         data_q  <= data_d;
         last_q  <= last_d;
      end
   end

   // Next-state and output decode; sccb_data/sccb_last are loaded on the
   // transition into SEND so they are valid for the whole start..done window.
   always_comb begin
      state_d    = state;
      idx_d      = idx;
      ph_d       = ph;
      cnt_d      = cnt;
      tcnt_d     = tcnt;
      entry_d    = entry_q;
      data_d     = data_q;
      last_d     = last_q;
      sccb_start = 1'b0;
      busy       = 1'b1;
      cfg_done   = 1'b0;
      cfg_err    = 1'b0;

      case (state)
         ST_IDLE: begin
            busy = 1'b0;
            if (init_go) begin
               idx_d   = '0;
               ph_d    = '0;
               state_d = ST_FETCH;
            end
         end

         ST_FETCH: begin
            entry_d = rom_entry;
            if (rom_entry.addr == CFG_DELAY_MARK) begin
               cnt_d   = DELAY_LOAD;
               state_d = ST_DELAY;
            end else begin
               data_d  = OV7670_WR_ID;
               last_d  = 1'b0;
               state_d = ST_SEND;
            end
         end

         ST_SEND: begin
            sccb_start = 1'b1;
            tcnt_d     = '0;
            state_d    = ST_WAIT;
         end

         ST_WAIT: begin
            if (tcnt != TO_MAX) tcnt_d = tcnt + TW'(1);
            // A done arriving on the final timeout cycle still counts.
            if (byte_done) begin
               if (ph != 2'd2) begin
                  ph_d    = ph + 2'd1;
                  data_d  = (ph == 2'd0) ? entry_q.addr : entry_q.val;
                  last_d  = (ph == 2'd1);
                  state_d = ST_SEND;
               end else begin
                  ph_d    = '0;
                  cnt_d   = GAP_LOAD;
                  state_d = ST_GAP;
               end
            end else if (tcnt >= TO_LAST) begin
               state_d = ST_ERR;
            end
         end

         // The wait ends as the counter reaches zero; with the following
         // FETCH this yields the full gap/delay length before the next start.
         ST_GAP, ST_DELAY: begin
            if (cnt <= 20'd1) begin
               cnt_d = '0;
               if (idx != 8'hFF) idx_d = idx + 8'd1;
               state_d = (idx >= IDX_LAST) ? ST_DONE : ST_FETCH;
            end else begin
               cnt_d = cnt - 20'd1;
            end
         end

         ST_DONE: begin
            busy     = 1'b0;
            cfg_done = 1'b1;
         end

         ST_ERR: begin
            busy    = 1'b0;
            cfg_err = 1'b1;
         end

         default: state_d = ST_IDLE;
      endcase
   end

   assign sccb_data = data_q;
   assign sccb_last = last_q;
   assign entry_idx = idx;

endmodule

// File: tb/tb_sccb_cfg_seq.sv
// tb/tb_sccb_cfg_seq.sv - directed self-checking bench for sccb_cfg_seq
`timescale 1ns/1ps
module tb_sccb_cfg_seq;

   localparam int GAP = 100;
   localparam int DLY = 300;
   localparam int TMO = 4096;
   localparam int RSP = 20;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       init_go = 1'b0;
   logic       resp_done = 1'b0;
   logic       inj_done = 1'b0;
   logic       resp_en = 1'b0;
   logic       byte_done;
   logic       sccb_start;
   logic [7:0] sccb_data;
   logic       sccb_last;
   logic       busy;
   logic       cfg_done;
   logic       cfg_err;
   logic [7:0] entry_idx;

   assign byte_done = resp_done | inj_done;

   always #5 clock = ~clock;

   sccb_cfg_seq #(
      .NUM_ENTRIES    (4),
      .GAP_CYCLES     (GAP),
      .DELAY_CYCLES   (DLY),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .init_go    (init_go),
      .byte_done  (byte_done),
      .sccb_start (sccb_start),
      .sccb_data  (sccb_data),
      .sccb_last  (sccb_last),
      .busy       (busy),
      .cfg_done   (cfg_done),
      .cfg_err    (cfg_err),
      .entry_idx  (entry_idx)
   );

   int         cyc = 0;
   logic [7:0] st_data[$];
   bit         st_last[$];
   int         st_cyc[$];
   int         dn_cyc[$];

   // cycle counter; records the cycle of each responder byte_done
   always @(posedge clock) begin
      if (resp_done) dn_cyc.push_back(cyc);
      cyc <= cyc + 1;
   end

   // start monitor
   always @(negedge clock) begin
      if (sccb_start) begin
         st_data.push_back(sccb_data);
         st_last.push_back(sccb_last);
         st_cyc.push_back(cyc);
      end
   end

   // sccb master model: byte_done RSP clocks after each start
   initial begin
      int cnt;
      cnt = 0;
      forever begin
         @(negedge clock);
         resp_done = 1'b0;
         if (!resp_en) cnt = 0;
         else if (cnt > 0) begin
            cnt--;
            if (cnt == 0) resp_done = 1'b1;
         end else if (sccb_start) cnt = RSP;
      end
   end

   int n_checks = 0;
   int n_fail = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clock);
      #1;
   endtask

   task automatic pulse_init();
      init_go = 1'b1;
      tick();
      init_go = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      repeat (3) tick();
      reset = 1'b1;
      tick();
   endtask

   task automatic wait_starts(input int n, input int budget, input string tag);
      for (int i = 0; i < budget && st_data.size() < n; i++) tick();
      check(tag, 32'(st_data.size() >= n), 32'd1);
   endtask

   logic [7:0] exp_data[9] = '{8'h42, 8'h12, 8'h80, 8'h42, 8'h12, 8'h04, 8'h42, 8'h40, 8'hD0};
   bit         exp_last[9] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

   initial begin
      int base;
      int k;
      int t_done;
      int t_err;

      // reset state
      #50;
      check("rst_start", 32'(sccb_start), 32'd0);
      check("rst_data", 32'(sccb_data), 32'h00);
      check("rst_last", 32'(sccb_last), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(cfg_done), 32'd0);
      check("rst_err", 32'(cfg_err), 32'd0);
      check("rst_idx", 32'(entry_idx), 32'd0);
      #50;
      reset = 1'b1;
      tick();

      // spurious byte_done in IDLE
      inj_done = 1'b1;
      tick();
      inj_done = 1'b0;
      repeat (3) tick();
      check("idle_done_nostart", 32'(st_data.size()), 32'd0);
      check("idle_done_busy", 32'(busy), 32'd0);
      check("idle_done_idx", 32'(entry_idx), 32'd0);

      // full run
      resp_en = 1'b1;
      pulse_init();
      check("run_busy", 32'(busy), 32'd1);
      for (int i = 0; i < 500 && dn_cyc.size() < 3; i++) tick();
      check("run_first_txn", 32'(dn_cyc.size() >= 3), 32'd1);
      repeat (5) tick();
      inj_done = 1'b1;
      tick();
      inj_done = 1'b0;
      tick();
      check("gap_done_idx", 32'(entry_idx), 32'd0);
      check("gap_done_busy", 32'(busy), 32'd1);
      for (int i = 0; i < 3000 && !cfg_done; i++) tick();
      t_done = cyc;
      check("run_cfg_done", 32'(cfg_done), 32'd1);
      check("run_busy_end", 32'(busy), 32'd0);
      check("run_err_end", 32'(cfg_err), 32'd0);
      check("run_idx_end", 32'(entry_idx), 32'd4);
      check("run_nbytes", 32'(st_data.size()), 32'd9);
      for (int i = 0; i < 9 && i < st_data.size(); i++) begin
         check($sformatf("run_byte%0d", i), 32'(st_data[i]), 32'(exp_data[i]));
         check($sformatf("run_last%0d", i), 32'(st_last[i]), 32'(exp_last[i]));
      end
      if (st_cyc.size() >= 9 && dn_cyc.size() >= 9) begin
         check("lat_ph0", 32'(st_cyc[1] - dn_cyc[0]), 32'd1);
         check("lat_ph1", 32'(st_cyc[2] - dn_cyc[1]), 32'd1);
         check("gap_idle", 32'(st_cyc[6] - dn_cyc[5] - 1), 32'(GAP));
         check("delay_idle", 32'(st_cyc[3] - dn_cyc[2] - 1), 32'(GAP + DLY));
         check("done_after_gap", 32'(t_done - dn_cyc[8]), 32'(GAP));
      end else begin
         check("run_timing_data", 32'd0, 32'd1);
      end

      // init_go held through DONE
      init_go = 1'b1;
      repeat (50) tick();
      init_go = 1'b0;
      check("done_hold_nostart", 32'(st_data.size()), 32'd9);
      check("done_hold_done", 32'(cfg_done), 32'd1);
      check("done_hold_busy", 32'(busy), 32'd0);

      // async reset mid-WAIT at idx 2, ph 1
      do_reset();
      pulse_init();
      wait_starts(14, 2000, "rr_reach");
      check("rr_byte", 32'(sccb_data), 32'h12);
      resp_en = 1'b0;
      repeat (3) tick();
      check("rr_idx_pre", 32'(entry_idx), 32'd2);
      check("rr_busy_pre", 32'(busy), 32'd1);
      reset = 1'b0;
      #1;
      check("rr_data", 32'(sccb_data), 32'h00);
      check("rr_busy", 32'(busy), 32'd0);
      check("rr_last", 32'(sccb_last), 32'd0);
      check("rr_idx", 32'(entry_idx), 32'd0);
      #2;
      reset = 1'b1;
      tick();
      base = st_data.size();
      pulse_init();
      wait_starts(base + 1, 50, "rr_restart");
      check("rr_restart_byte", 32'(sccb_data), 32'h42);
      check("rr_restart_idx", 32'(entry_idx), 32'd0);

      // timeout with no byte_done
      do_reset();
      base = st_data.size();
      pulse_init();
      wait_starts(base + 1, 50, "to_start");
      k = st_cyc[st_cyc.size() - 1];
      for (int i = 0; i < TMO + 100 && !cfg_err; i++) tick();
      t_err = cyc;
      check("to_err", 32'(cfg_err), 32'd1);
      check("to_cycles", 32'(t_err - k), 32'(TMO + 1));
      check("to_busy", 32'(busy), 32'd0);
      check("to_idx", 32'(entry_idx), 32'd0);
      repeat (30) tick();
      check("to_nostart", 32'(st_data.size()), 32'(base + 1));
      check("to_sticky", 32'(cfg_err), 32'd1);

      // byte_done on the exact timeout cycle
      do_reset();
      base = st_data.size();
      pulse_init();
      wait_starts(base + 1, 50, "edge_start");
      k = st_cyc[st_cyc.size() - 1];
      repeat (TMO) tick();
      inj_done = 1'b1;
      tick();
      inj_done = 1'b0;
      check("edge_err", 32'(cfg_err), 32'd0);
      check("edge_busy", 32'(busy), 32'd1);
      check("edge_nstart", 32'(st_data.size()), 32'(base + 2));
      if (st_data.size() >= base + 2) begin
         check("edge_byte", 32'(st_data[base + 1]), 32'h12);
         check("edge_cycle", 32'(st_cyc[base + 1] - k), 32'(TMO + 1));
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
